// File: rtl/johnson_counter_n.sv
// rtl/johnson_counter_n.sv - parametrised Johnson / one-hot ring counter
// with phase load, decoded phase index, wrap pulse and illegal-state correction.
module johnson_counter_n #(
  parameter int WIDTH        = 4,
  parameter int MODE         = 0,
  parameter int SELF_CORRECT = 1,
  localparam int PW          = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [PW-1:0]    load_phase,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             illegal
);

  localparam int P = (MODE == 0) ? 2 * WIDTH : WIDTH;
  localparam logic [WIDTH-1:0] RESET_Q = (MODE == 0) ? '0 : WIDTH'(1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(P - 1);

  // State word for a phase index (index assumed already < P).
  function automatic logic [WIDTH-1:0] enc(input logic [PW-1:0] k);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MODE == 0)
        r[i] = (int'(k) < WIDTH) ? (i < int'(k)) : (i >= int'(k) - WIDTH);
      else
        r[i] = (i == int'(k));
    end
    return r;
  endfunction

  // Phase index of a state word; only meaningful for legal states.
  function automatic logic [PW-1:0] dec(input logic [WIDTH-1:0] s);
    logic [PW-1:0] r;
    int c;
    r = '0;
    c = 0;
    if (MODE == 0) begin
      for (int i = 0; i < WIDTH; i++)
        if (s[i]) c++;
      r = s[WIDTH-1] ? PW'(2 * WIDTH - c) : PW'(c);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (s[i]) r = PW'(i);
    end
    return r;
  endfunction

  logic [WIDTH-1:0] fwd_q;
  logic [WIDTH-1:0] rev_q;
  logic [PW-1:0]    load_idx;
  logic [WIDTH-1:0] next_q;
  logic             next_wrap;

  // A state is legal exactly when it survives a decode/encode round trip.
  assign illegal = (enc(dec(q)) != q);

  always_comb begin
    if (MODE == 0) begin
      fwd_q = {q[WIDTH-2:0], ~q[WIDTH-1]};
      rev_q = {~q[0], q[WIDTH-1:1]};
    end else begin
      fwd_q = {q[WIDTH-2:0], q[WIDTH-1]};
      rev_q = {q[0], q[WIDTH-1:1]};
    end
  end

  assign load_idx = (int'(load_phase) >= P) ? '0 : load_phase;

  always_comb begin
    next_q    = q;
    next_wrap = 1'b0;
    if (load) begin
      next_q = enc(load_idx);
    end else if ((SELF_CORRECT != 0) && illegal) begin
      next_q = RESET_Q;
    end else if (en) begin
      next_q    = dir ? rev_q : fwd_q;
      next_wrap = !illegal && (dir ? (phase == '0) : (phase == LAST_PHASE));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= RESET_Q;
      phase <= '0;
      wrap  <= 1'b0;
    end else begin
      q     <= next_q;
      phase <= dec(next_q);
      wrap  <= next_wrap;
    end
  end

endmodule

// File: tb/tb_johnson_counter_n.sv
// tb/tb_johnson_counter_n.sv - scoreboard bench for johnson_counter_n
// (W4 Johnson with/without correction, W5 one-hot ring).
module tb_johnson_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r0, e0, d0, l0;
  logic [2:0] lp0;
  logic [3:0] q0;
  logic [2:0] ph0;
  logic       w0, il0;

  logic       r1, e1, d1, l1;
  logic [2:0] lp1;
  logic [3:0] q1;
  logic [2:0] ph1;
  logic       w1, il1;

  logic       r2, e2, d2, l2;
  logic [3:0] lp2;
  logic [4:0] q2;
  logic [3:0] ph2;
  logic       w2, il2;

  johnson_counter_n #(.WIDTH(4), .MODE(0), .SELF_CORRECT(1)) dut (
    .clk(clk), .reset(r0), .en(e0), .dir(d0), .load(l0), .load_phase(lp0),
    .q(q0), .phase(ph0), .wrap(w0), .illegal(il0));

  johnson_counter_n #(.WIDTH(4), .MODE(0), .SELF_CORRECT(0)) dut_nc (
    .clk(clk), .reset(r1), .en(e1), .dir(d1), .load(l1), .load_phase(lp1),
    .q(q1), .phase(ph1), .wrap(w1), .illegal(il1));

  johnson_counter_n #(.WIDTH(5), .MODE(1), .SELF_CORRECT(1)) dut_r (
    .clk(clk), .reset(r2), .en(e2), .dir(d2), .load(l2), .load_phase(lp2),
    .q(q2), .phase(ph2), .wrap(w2), .illegal(il2));

  typedef struct {
    int         u;
    logic [4:0] q;
    logic [3:0] ph;
    logic       w;
    logic       il;
    bit         full;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [3:0] fq  [0:8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
  logic [2:0] fph [0:8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
  logic       fw  [0:8] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic [3:0] rq  [0:7] = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
  logic [4:0] gq  [0:5] = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h01, 5'h02};
  logic [3:0] gph [0:5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
  logic       gw  [0:5] = '{0, 0, 0, 0, 1, 0};
  logic [3:0] nq  [0:2] = '{4'b1011, 4'b0110, 4'b1101};

  task automatic push(input int u, input logic [4:0] q, input logic [3:0] ph,
                      input logic w, input logic il, input bit full, input string nm);
    exp_t e;
    e.u = u; e.q = q; e.ph = ph; e.w = w; e.il = il; e.full = full; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic chk1(input string nm, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b, want %b", nm, act, want);
    end
  endtask

  // Monitor: every entry pushed before a rising edge is checked just after it.
  initial begin
    exp_t e;
    logic [4:0] aq;
    logic [3:0] ap;
    logic aw, ai;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.u)
          0:       begin aq = {1'b0, q0}; ap = {1'b0, ph0}; aw = w0; ai = il0; end
          1:       begin aq = {1'b0, q1}; ap = {1'b0, ph1}; aw = w1; ai = il1; end
          default: begin aq = q2;         ap = ph2;         aw = w2; ai = il2; end
        endcase
        checks++;
        if (aq !== e.q || ai !== e.il || (e.full && (ap !== e.ph || aw !== e.w))) begin
          errors++;
          $display("FAIL %s: got q=%h phase=%0d wrap=%b illegal=%b, want q=%h phase=%0d wrap=%b illegal=%b",
                   e.nm, aq, ap, aw, ai, e.q, e.ph, e.w, e.il);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    r0 = 1; e0 = 0; d0 = 0; l0 = 0; lp0 = 0;
    r1 = 1; e1 = 0; d1 = 0; l1 = 0; lp1 = 0;
    r2 = 1; e2 = 0; d2 = 0; l2 = 0; lp2 = 0;

    repeat (3) begin
      @(negedge clk);
      push(0, 5'h00, 4'd0, 0, 0, 1, "reset_j");
      push(1, 5'h00, 4'd0, 0, 0, 1, "reset_nc");
      push(2, 5'h01, 4'd0, 0, 0, 1, "reset_ring");
    end

    // Johnson forward, wrap on 8 -> 0
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      r0 = 0; r1 = 0; r2 = 0; e0 = 1; d0 = 0;
      push(0, {1'b0, fq[i]}, {1'b0, fph[i]}, fw[i], 0, 1, "fwd");
    end

    @(negedge clk); d0 = 1;
    push(0, 5'h00, 4'd0, 0, 0, 1, "rev_to_0");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      push(0, {1'b0, rq[i]}, 4'(7 - i), (i == 0), 0, 1, "rev");
    end
    repeat (2) begin
      @(negedge clk); e0 = 0;
      push(0, 5'h00, 4'd0, 0, 0, 1, "hold");
    end

    // Load, including a load from the last phase that must not wrap
    @(negedge clk); l0 = 1; lp0 = 3'd5; e0 = 1; d0 = 0;
    push(0, 5'h0E, 4'd5, 0, 0, 1, "load5");
    @(negedge clk); lp0 = 3'd7;
    push(0, 5'h08, 4'd7, 0, 0, 1, "load7");
    @(negedge clk); lp0 = 3'd0;
    push(0, 5'h00, 4'd0, 0, 0, 1, "load0_nowrap");
    @(negedge clk); r0 = 1; lp0 = 3'd5;
    push(0, 5'h00, 4'd0, 0, 0, 1, "load_vs_reset");

    // Reset mid-sequence
    @(negedge clk); r0 = 0; l0 = 0; e0 = 1; d0 = 0;
    push(0, 5'h01, 4'd1, 0, 0, 1, "pre_rst1");
    @(negedge clk); push(0, 5'h03, 4'd2, 0, 0, 1, "pre_rst2");
    @(negedge clk); push(0, 5'h07, 4'd3, 0, 0, 1, "pre_rst3");
    @(negedge clk); r0 = 1;
    push(0, 5'h00, 4'd0, 0, 0, 1, "mid_reset");
    @(negedge clk); r0 = 0;
    push(0, 5'h01, 4'd1, 0, 0, 1, "post_reset");

    // Illegal state with self-correction
    @(negedge clk); e0 = 0;
    force dut.q = 4'b0101;
    #1 chk1("illegal_flag_sc", il0, 1'b1);
    release dut.q;
    push(0, 5'h00, 4'd0, 0, 0, 1, "self_correct");
    @(negedge clk); e0 = 1;
    push(0, 5'h01, 4'd1, 0, 0, 1, "after_correct");

    // Illegal state without correction keeps shifting
    @(negedge clk); e1 = 0;
    force dut_nc.q = 4'b0101;
    #1 chk1("illegal_flag_nc", il1, 1'b1);
    release dut_nc.q;
    e1 = 1; d1 = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      push(1, {1'b0, nq[i]}, 4'd0, 0, 1, 0, "no_correct");
    end

    // One-hot ring, W=5
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); e1 = 0; e2 = 1; d2 = 0;
      push(2, gq[i], gph[i], gw[i], 0, 1, "ring_fwd");
    end
    @(negedge clk); d2 = 1;
    push(2, 5'h01, 4'd0, 0, 0, 1, "ring_rev0");
    @(negedge clk); push(2, 5'h10, 4'd4, 1, 0, 1, "ring_rev_wrap");
    @(negedge clk); push(2, 5'h08, 4'd3, 0, 0, 1, "ring_rev3");
    @(negedge clk); l2 = 1; lp2 = 4'd12;
    push(2, 5'h01, 4'd0, 0, 0, 1, "ring_load_clamp");
    @(negedge clk); lp2 = 4'd3;
    push(2, 5'h08, 4'd3, 0, 0, 1, "ring_load3");
    @(negedge clk); lp2 = 4'd5;
    push(2, 5'h01, 4'd0, 0, 0, 1, "ring_load_p");
    @(negedge clk); l2 = 0; e2 = 0;
    push(2, 5'h01, 4'd0, 0, 0, 1, "ring_hold");

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
